eth_parser_monitor: RTL
=======================

# eth_parser_monitor

Board-level activity and statistics monitor that sits directly downstream of the Ethernet subsystem's parser outputs on the AX7203 top level. It consumes the parser's per-beat valid, last and metadata-valid strobes, tracks frame boundaries with a small FSM, keeps saturating frame counters, and drives the four board LEDs with human-visible stretched pulses plus a heartbeat. It replaces the direct strobe-to-LED wiring, which is invisible at 125 MHz.

## Interface
- STRETCH_CYCLES, 12_500_000, LED on-time per event in clk cycles (100 ms at 125 MHz); minimum 1
- HB_CYCLES, 62_500_000, heartbeat half-period in clk cycles (0.5 s); minimum 1
- CNT_W, 16, width of the statistics counters
- clk_125mhz  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- parser_valid  input  1  parser data beat valid
- parser_last  input  1  last beat of frame; qualified by parser_valid
- parser_meta_valid  input  1  header metadata extracted; single-cycle strobe, not qualified by parser_valid
- led  output  4  [0] rx activity, [1] frame done, [2] metadata miss, [3] heartbeat
- frame_cnt  output  CNT_W  completed frames, saturating
- meta_miss_cnt  output  CNT_W  frames that ended without a metadata strobe, saturating
- in_frame  output  1  FSM is in S_FRAME

## Operation
- FSM states: S_IDLE, S_FRAME.
  - S_IDLE + parser_valid & !parser_last -> S_FRAME; clear meta_seen, then set it if parser_meta_valid that cycle.
  - S_IDLE + parser_valid & parser_last -> single-beat frame; end-of-frame processing; stay in S_IDLE.
  - S_FRAME + parser_meta_valid -> set meta_seen.
  - S_FRAME + parser_valid & parser_last -> end-of-frame processing; -> S_IDLE.
  - parser_last without parser_valid is ignored in every state.
- End-of-frame: frame_cnt += 1. If neither meta_seen nor parser_meta_valid is asserted in the same cycle, meta_miss_cnt += 1 and a miss event fires. Always fires a done event.
- Counters saturate at all-ones and never wrap.
- Stretchers: an event loads STRETCH_CYCLES into a down-counter; the LED is high while the count is nonzero. A re-trigger while counting reloads to the full value and does not add time.
  - led[0] is triggered by every parser_valid beat.
  - led[1] is triggered by the done event; led[2] by the miss event.
- Heartbeat: a free-running counter toggles led[3] every HB_CYCLES cycles.

## Timing
- All outputs are registered. Reset values: led = 0, frame_cnt = 0, meta_miss_cnt = 0, in_frame = 0. FSM = S_IDLE, meta_seen = 0, all stretch and heartbeat counters = 0.
- Event to LED rise: 1 cycle. The LED stays high exactly STRETCH_CYCLES cycles after the last trigger.
- End-of-frame beat at cycle N: counters updated and visible at N+1.
- in_frame rises the cycle after the first non-last beat. It falls the cycle after the last beat.
- A metadata strobe on the same cycle as the last beat counts as seen.
- A metadata strobe in S_IDLE with no beat is discarded.
- Asserting rst_n low mid-frame returns everything to reset values immediately. A frame in progress is dropped and not counted.
- led[3] first toggles HB_CYCLES cycles after reset release.

## Configuration
- ETH_MON_STATS_EN:
  - Defined: frame_cnt and meta_miss_cnt are implemented as specified.
  - Undefined: both outputs are tied to 0, and the counter flops are not synthesized. The FSM, LEDs and in_frame are unchanged.

## Structure
- Package eth_mon_pkg contains:
  - typedef enum logic {S_IDLE, S_FRAME} mon_state_t
  - localparams for the default STRETCH_CYCLES and HB_CYCLES at 125 MHz
  - LED index constants LED_RX, LED_DONE, LED_MISS, LED_HB
- Sub-module pulse_stretcher (parameter CYCLES; ports: clk, rst_n, trig, out), instantiated three times.
- Counter widths are sized with $clog2(CYCLES+1).

## Test plan
All scenarios use STRETCH_CYCLES=4, HB_CYCLES=8, CNT_W=4.
- Reset, then 20 idle cycles -> led[2:0] = 0, counters = 0; led[3] toggles at cycles 8 and 16 after release.
- 3-beat frame with meta on beat 2 -> in_frame high for 2 cycles; frame_cnt = 1, meta_miss_cnt = 0. led[1] high 4 cycles starting the cycle after the last beat; led[0] high 6 cycles.
- Single-beat frame (valid & last together), no meta -> frame_cnt = 1, meta_miss_cnt = 1, in_frame never rises, led[2] high 4 cycles.
- Meta strobe on the same cycle as last -> meta_miss_cnt unchanged. Meta strobe alone in S_IDLE -> no effect on counters or LEDs.
- 20 back-to-back single-beat frames without meta -> both counters saturate at 15. led[1] stays high until 4 cycles after the final frame.
- rst_n pulsed low mid-frame, then a 2-beat frame -> frame_cnt = 1 and outputs return to 0 during reset. With ETH_MON_STATS_EN undefined, the same stimulus gives counters = 0.

Source files
------------

// File: rtl/eth_mon_pkg.sv
// Shared types and constants for the Ethernet parser activity/statistics monitor.
package eth_mon_pkg;

  typedef enum logic {S_IDLE, S_FRAME} mon_state_t;

  // 100 ms LED on-time and 0.5 s heartbeat half-period at 125 MHz.
  localparam int unsigned STRETCH_CYCLES_DEFAULT = 12_500_000;
  localparam int unsigned HB_CYCLES_DEFAULT      = 62_500_000;

  localparam int unsigned LED_RX   = 0;
  localparam int unsigned LED_DONE = 1;
  localparam int unsigned LED_MISS = 2;
  localparam int unsigned LED_HB   = 3;

endpackage

// File: rtl/pulse_stretcher.sv
// Retriggerable pulse stretcher: output stays high CYCLES cycles after the last trigger.
module pulse_stretcher #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic out
);

  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] Load = W'(CYCLES);
  localparam logic [W-1:0] One  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // A retrigger reloads to the full value rather than extending.
  always_comb begin
    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = Load;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out   <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/eth_parser_monitor.sv
// Parser frame-boundary tracker with saturating statistics and stretched board LEDs.
// Statistics counters are built only when ETH_MON_STATS_EN is defined.
module eth_parser_monitor
  import eth_mon_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = STRETCH_CYCLES_DEFAULT,
  parameter int unsigned HB_CYCLES      = HB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_125mhz,
  input  logic             rst_n,
  input  logic             parser_valid,
  input  logic             parser_last,
  input  logic             parser_meta_valid,
  output logic [3:0]       led,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] meta_miss_cnt,
  output logic             in_frame
);

  localparam int unsigned HbW = $clog2(HB_CYCLES + 1);
  localparam logic [HbW-1:0] HbLast = HbW'(HB_CYCLES - 1);
  localparam logic [HbW-1:0] HbOne  = HbW'(1);

  mon_state_t     state_q;
  logic           meta_seen_q;
  logic           eof;
  logic           meta_hit;
  logic           miss_evt;
  logic [HbW-1:0] hb_cnt_q;
  logic           hb_q;

  assign eof      = parser_valid & parser_last;
  // meta_seen is stale in S_IDLE; only the current strobe counts for a single-beat frame.
  assign meta_hit = parser_meta_valid | ((state_q == S_FRAME) & meta_seen_q);
  assign miss_evt = eof & ~meta_hit;
  assign in_frame = (state_q == S_FRAME);

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      meta_seen_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (parser_valid && !parser_last) begin
            state_q     <= S_FRAME;
            meta_seen_q <= parser_meta_valid;
          end
        end
        S_FRAME: begin
          if (parser_meta_valid) meta_seen_q <= 1'b1;
          if (eof) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ETH_MON_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      meta_miss_cnt <= '0;
    end else if (eof) begin
      if (frame_cnt != '1) frame_cnt <= frame_cnt + CntOne;
      if (miss_evt && meta_miss_cnt != '1) meta_miss_cnt <= meta_miss_cnt + CntOne;
    end
  end
`else
  assign frame_cnt     = '0;
  assign meta_miss_cnt = '0;
`endif

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HbLast) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + HbOne;
    end
  end

  assign led[LED_HB] = hb_q;

  pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_rx_stretch (
    .clk   (clk_125mhz),
    .rst_n (rst_n),
    .trig  (parser_valid),
    .out   (led[LED_RX])
  );

  pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_done_stretch (
    .clk   (clk_125mhz),
    .rst_n (rst_n),
    .trig  (eof),
    .out   (led[LED_DONE])
  );

  pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_miss_stretch (
    .clk   (clk_125mhz),
    .rst_n (rst_n),
    .trig  (miss_evt),
    .out   (led[LED_MISS])
  );

endmodule
